line_buffer_loader: RTL

Fills the 3-row LineBuffer feeding `convolve` from a single-port image memory, one 3-pixel column per write. It is the writer-side counterpart of `convolve`: the loader writes a full 3×COLS stripe, then holds `stripe_valid` until `convolve` signals it has consumed the stripe. It then advances the base row by the latched stride and reloads, until the image is exhausted. It sits in `top` between the image memory and `LineBuffer.wr_en/data_in_r*`.

---
 rtl/line_buffer_loader_pkg.sv | 22 ++
 rtl/lbl_addr_gen.sv | 70 +++++++
 rtl/line_buffer_loader.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/line_buffer_loader_pkg.sv
// rtl/line_buffer_loader_pkg.sv - shared types, constants and helpers for the line buffer loader
package line_buffer_loader_pkg;

    localparam int LB_COLS  = 28;
    localparam int IMG_ROWS = 28;

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        RD1,
        RD2,
        WR,
        READY,
        FIN
    } lbl_state_t;

    // A stride of zero would never advance the stripe, so it is treated as one.
    function automatic logic [1:0] normalize_stride(input logic [1:0] stride);
        return (stride == 2'd0) ? 2'd1 : stride;
    endfunction

endpackage

// File: rtl/lbl_addr_gen.sv
// rtl/lbl_addr_gen.sv - row-base/column counters and incremental image address generator
module lbl_addr_gen #(
    parameter int COLS     = 28,
    parameter int NUM_ROWS = 28,
    parameter int ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [1:0]        stride_n,
    input  logic              addr_inc,
    input  logic              col_adv,
    input  logic              row_adv,
    output logic [ADDR_W-1:0] addr,
    output logic              last_col,
    output logic              last_stripe
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(NUM_ROWS) + 2;
    localparam logic [ADDR_W-1:0] COLS_X1 = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] COLS_X2 = ADDR_W'(2 * COLS);

    logic [CW-1:0]     col;
    logic [RW-1:0]     base_row;
    logic [1:0]        stride_q;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] col_addr;
    logic [ADDR_W-1:0] row_step;
    logic [ADDR_W-1:0] next_base;

    // col_addr tracks base_addr+col so the next column's RD0 address is a single increment.
    assign next_base   = base_addr + row_step;
    assign last_col    = (col == CW'(COLS - 1));
    assign last_stripe = (base_row + RW'(stride_q) + RW'(2)) > RW'(NUM_ROWS - 1);

    // Counter and address registers; the row step (stride*COLS) is built from shifted adds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col       <= '0;
            base_row  <= '0;
            stride_q  <= '0;
            base_addr <= '0;
            col_addr  <= '0;
            row_step  <= '0;
            addr      <= '0;
        end else if (load) begin
            col       <= '0;
            base_row  <= '0;
            stride_q  <= stride_n;
            base_addr <= '0;
            col_addr  <= '0;
            row_step  <= (stride_n[1] ? COLS_X2 : '0) + (stride_n[0] ? COLS_X1 : '0);
            addr      <= '0;
        end else if (row_adv) begin
            col       <= '0;
            base_row  <= base_row + RW'(stride_q);
            base_addr <= next_base;
            col_addr  <= next_base;
            addr      <= next_base;
        end else if (col_adv) begin
            col       <= col + CW'(1);
            col_addr  <= col_addr + ADDR_W'(1);
            addr      <= col_addr + ADDR_W'(1);
        end else if (addr_inc) begin
            addr      <= addr + COLS_X1;
        end
    end

endmodule

// File: rtl/line_buffer_loader.sv
// rtl/line_buffer_loader.sv - loads 3-row stripes from image memory into the convolve line buffer
module line_buffer_loader
    import line_buffer_loader_pkg::*;
#(
    parameter int BIT_DEPTH = 8,
    parameter int COLS      = LB_COLS,
    parameter int IMG_ROWS  = line_buffer_loader_pkg::IMG_ROWS,
    parameter int ADDR_W    = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           stride,
    input  logic                 row_done,
    output logic                 img_rd_en,
    output logic [ADDR_W-1:0]    img_rd_addr,
    input  logic [BIT_DEPTH-1:0] img_rd_data,
    output logic                 lb_wr_en,
    output logic [BIT_DEPTH-1:0] lb_data_r1,
    output logic [BIT_DEPTH-1:0] lb_data_r2,
    output logic [BIT_DEPTH-1:0] lb_data_r3,
    output logic                 stripe_valid,
    output logic                 busy,
    output logic                 done
);

    lbl_state_t state;
    lbl_state_t state_nxt;

    logic load;
    logic addr_inc;
    logic col_adv;
    logic row_adv;
    logic last_col;
    logic last_stripe;

    lbl_addr_gen #(
        .COLS     (COLS),
        .NUM_ROWS (IMG_ROWS),
        .ADDR_W   (ADDR_W)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .stride_n    (normalize_stride(stride)),
        .addr_inc    (addr_inc),
        .col_adv     (col_adv),
        .row_adv     (row_adv),
        .addr        (img_rd_addr),
        .last_col    (last_col),
        .last_stripe (last_stripe)
    );

    assign img_rd_en = (state == RD0) || (state == RD1) || (state == RD2);
    assign busy      = (state != IDLE);
    assign done      = (state == FIN);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and counter strobes toward the address generator.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        addr_inc  = 1'b0;
        col_adv   = 1'b0;
        row_adv   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RD0;
                end
            end
            RD0: begin
                addr_inc  = 1'b1;
                state_nxt = RD1;
            end
            RD1: begin
                addr_inc  = 1'b1;
                state_nxt = RD2;
            end
            RD2: begin
                state_nxt = WR;
            end
            WR: begin
                if (last_col) begin
                    state_nxt = READY;
                end else begin
                    col_adv   = 1'b1;
                    state_nxt = RD0;
                end
            end
            READY: begin
                if (row_done) begin
                    if (last_stripe) begin
                        state_nxt = FIN;
                    end else begin
                        row_adv   = 1'b1;
                        state_nxt = RD0;
                    end
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Capture each row's pixel one cycle after its read, then strobe the column into the buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lb_data_r1   <= '0;
            lb_data_r2   <= '0;
            lb_data_r3   <= '0;
            lb_wr_en     <= 1'b0;
            stripe_valid <= 1'b0;
        end else begin
            if (state == RD1) begin
                lb_data_r1 <= img_rd_data;
            end
            if (state == RD2) begin
                lb_data_r2 <= img_rd_data;
            end
            if (state == WR) begin
                lb_data_r3 <= img_rd_data;
            end
            lb_wr_en     <= (state == WR);
            stripe_valid <= (state == READY) && (state_nxt == READY);
        end
    end

endmodule
